// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES round engine.
//   - state_t  : engine FSM states (IDLE/RUN/DONE)
//   - ip64/fp64: DES initial and final permutations (DES bit 1 = bit 63)
//   - rpc_legal: legal unrolling factors for ROUNDS_PER_CYCLE
//   - key_idx  : zero-based round-key index for round i (K(idx+1) is used)
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Entry n (0-based) names the DES input bit (1-based) that lands on output bit n+1.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  function automatic bit rpc_legal(input int rpc);
    return (rpc == 1) || (rpc == 2) || (rpc == 4) || (rpc == 8) || (rpc == 16);
  endfunction

  function automatic logic [63:0] ip64(input logic [63:0] b);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[63-i] = b[64-IP_TAB[i]];
    end
    return o;
  endfunction

  function automatic logic [63:0] fp64(input logic [63:0] b);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[63-i] = b[64-FP_TAB[i]];
    end
    return o;
  endfunction

  // Decryption walks the key list backwards: round i uses K(16-i).
  function automatic logic [3:0] key_idx(input logic [3:0] i, input logic decrypt);
    return decrypt ? (4'd15 - i) : i;
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one Feistel round, L' = R, R' = L ^ f(R, K).
//   i_l, i_r [31:0] : halves entering the round
//   i_k     [47:0]  : round key for this round
//   o_l, o_r [31:0] : halves leaving the round
module des_round
  import des_pkg::*;
(
  input  logic [31:0] i_l,
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_l,
  output logic [31:0] o_r
);

  logic [31:0] w_f;

  fblock u_fblock (
    .i_r (i_r),
    .i_k (i_k),
    .o_f (w_f)
  );

  assign o_l = i_r;
  assign o_r = i_l ^ w_f;

endmodule

// File: rtl/fblock.sv
// fblock: DES f-function f(R, K) = P(S(E(R) ^ K)).
//   i_r [31:0] : right half, DES bit 1 = bit 31
//   i_k [47:0] : round key, DES bit 1 = bit 47
//   o_f [31:0] : f-function result
module fblock (
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_f
);

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Row-major S-boxes: entry index = row*16 + col.
  localparam int S_TAB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  logic [47:0] w_e;
  logic [47:0] w_x;
  logic [31:0] w_s;

  for (genvar gi = 0; gi < 48; gi++) begin : g_e
    assign w_e[47-gi] = i_r[32-E_TAB[gi]];
  end

  assign w_x = w_e ^ i_k;

  // Outer bits (1 and 6 of each 6-bit group) select the row, inner four the column.
  for (genvar gi = 0; gi < 8; gi++) begin : g_s
    logic [5:0] w_six;
    assign w_six = w_x[47-6*gi -: 6];
    assign w_s[31-4*gi -: 4] = 4'(S_TAB[gi][{w_six[5], w_six[0], w_six[4:1]}]);
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_p
    assign o_f[31-gi] = w_s[32-P_TAB[gi]];
  end

endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: multi-cycle DES data path (IP, 16 Feistel rounds, FP)
// consuming externally generated round keys.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid/in_ready, in_block, in_keys (Kn at [48n-1:48n-48]), in_decrypt
//   out_valid/out_ready, out_block : registered result, held until retired
//   busy          : high while a block is in RUN or DONE
// ROUNDS_PER_CYCLE rounds are chained combinationally per clock; the block
// takes 16/ROUNDS_PER_CYCLE RUN cycles.
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [767:0] in_keys,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy
);

  localparam int         RPC     = ROUNDS_PER_CYCLE;
  localparam int         N_CYC   = 16 / RPC;
  localparam logic [3:0] RC_LAST = 4'(N_CYC - 1);

  if (!rpc_legal(RPC)) begin : g_bad_rpc
    $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t         r_state;
  state_t         w_state_next;
  logic [31:0]    r_l;
  logic [31:0]    r_r;
  logic [767:0]   r_keys;
  logic           r_dec;
  logic [3:0]     r_rc;
  logic [63:0]    r_out;

  logic           w_accept;
  logic           w_last;
  logic           w_retire;
  logic [63:0]    w_ip;

  logic [47:0]    w_key_arr [16];
  logic [31:0]    w_l [RPC+1];
  logic [31:0]    w_r [RPC+1];

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_rc == RC_LAST);
  assign w_retire = (r_state == ST_DONE) && out_ready;
  assign w_ip     = ip64(in_block);

  // Key register viewed as K1..K16 for the 16:1 key-select mux.
  for (genvar gi = 0; gi < 16; gi++) begin : g_keys
    assign w_key_arr[gi] = r_keys[48*gi +: 48];
  end

  assign w_l[0] = r_l;
  assign w_r[0] = r_r;

  // Round chain; the round number is rc*RPC + gi, which never exceeds 15,
  // so 4-bit wrap-around arithmetic is exact (for RPC=16 rc is always 0).
  for (genvar gi = 0; gi < RPC; gi++) begin : g_round
    logic [3:0]  w_ridx;
    logic [47:0] w_k;

    assign w_ridx = (r_rc * 4'(RPC)) + 4'(gi);
    assign w_k    = w_key_arr[key_idx(w_ridx, r_dec)];

    des_round u_round (
      .i_l (w_l[gi]),
      .i_r (w_r[gi]),
      .i_k (w_k),
      .o_l (w_l[gi+1]),
      .o_r (w_r[gi+1])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)   w_state_next = ST_DONE;
      ST_DONE: if (w_retire) w_state_next = ST_IDLE;
      default:               w_state_next = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy     = 1'b1;
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_block = r_out;

  // Data path. The final edge stores FP({R16, L16}), undoing the last swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l    <= '0;
      r_r    <= '0;
      r_keys <= '0;
      r_dec  <= 1'b0;
      r_rc   <= '0;
      r_out  <= '0;
    end else begin
      if (w_accept) begin
        r_l    <= w_ip[63:32];
        r_r    <= w_ip[31:0];
        r_keys <= in_keys;
        r_dec  <= in_decrypt;
        r_rc   <= '0;
      end else if (r_state == ST_RUN) begin
        r_l <= w_l[RPC];
        r_r <= w_r[RPC];
        if (w_last) begin
          r_out <= fp64({w_r[RPC], w_l[RPC]});
        end else begin
          r_rc <= r_rc + 4'd1;
        end
      end else if (w_retire) begin
        r_rc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
module tb_des_round_engine;

  localparam int NI = 5;
  localparam int RPC_T [NI] = '{1, 2, 4, 8, 16};
  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] GOLD_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] GOLD_CT  = 64'h85E813540F0AB405;

  // Reference DES tables (textbook form, DES bit 1 = MSB).
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
    64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5,
    63,55,47,39,31,23,15,7};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,
    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         in_decrypt;
  logic [63:0]  in_block;
  logic [767:0] in_keys;
  logic         in_ready_v  [NI];
  logic         out_valid_v [NI];
  logic         busy_v      [NI];
  logic [63:0]  out_block_v [NI];

  logic         lit_en;
  logic [63:0]  lit_val;
  logic [767:0] gold_ks;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    des_round_engine #(.ROUNDS_PER_CYCLE(RPC_T[gi])) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready_v[gi]),
      .in_block   (in_block),
      .in_keys    (in_keys),
      .in_decrypt (in_decrypt),
      .out_valid  (out_valid_v[gi]),
      .out_ready  (out_ready),
      .out_block  (out_block_v[gi]),
      .busy       (busy_v[gi])
    );
  end

  // ---------------- behavioural DES reference ----------------
  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int          row;
    int          col;
    for (int n = 1; n <= 48; n++) e[48-n] = r[32-E_T[n-1]];
    e = e ^ k;
    for (int g = 0; g < 8; g++) begin
      b = e[47-6*g -: 6];
      row = 2 * int'(b[5]) + int'(b[0]);
      col = int'(b[4:1]);
      s[31-4*g -: 4] = 4'(S_T[g][row*16 + col]);
    end
    for (int n = 1; n <= 32; n++) p[32-n] = s[32-P_T[n-1]];
    return p;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [767:0] ks,
                                          input logic dec);
    logic [63:0] t;
    logic [63:0] o;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] nl;
    int          kn;
    for (int n = 1; n <= 64; n++) t[64-n] = blk[64-IP_T[n-1]];
    l = t[63:32];
    r = t[31:0];
    for (int i = 1; i <= 16; i++) begin
      kn = dec ? 17 - i : i;
      nl = r;
      r  = l ^ f_ref(r, ks[48*kn-1 -: 48]);
      l  = nl;
    end
    t = {r, l};
    // Final permutation is the inverse of IP.
    for (int n = 1; n <= 64; n++) o[64-IP_T[n-1]] = t[64-n];
    return o;
  endfunction

  function automatic logic [767:0] ksched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [767:0] ks;
    for (int n = 1; n <= 56; n++) cd[56-n] = key[64-PC1_T[n-1]];
    c = cd[55:28];
    d = cd[27:0];
    ks = '0;
    for (int i = 1; i <= 16; i++) begin
      for (int s = 0; s < SH_T[i-1]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int m = 1; m <= 48; m++) ks[48*i-m] = cd[56-PC2_T[m-1]];
    end
    return ks;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [rpc=%0d] t=%0t: got %h want %h", nm, RPC_T[inst], $time, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  bit          m_busy [NI];
  int          m_cyc  [NI];
  logic [63:0] m_exp  [NI];
  bit          m_lit  [NI];
  logic [63:0] m_litv [NI];
  bit          acc_n  [NI];
  bit          ret_n  [NI];
  bit          k1_done = 1'b0;
  int          nlat;
  bit          exp_done;

  always begin
    @(negedge clk or posedge rst);
    #1;
    if (!k1_done) begin
      chk("k1_model", 0, {16'd0, gold_ks[47:0]}, 64'h1B02EFFC7072);
      k1_done = 1'b1;
    end
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        chk("rst_in_ready", k, 64'(in_ready_v[k]), 64'd1);
        chk("rst_out_valid", k, 64'(out_valid_v[k]), 64'd0);
        chk("rst_busy", k, 64'(busy_v[k]), 64'd0);
        chk("rst_out_block", k, out_block_v[k], 64'd0);
        m_busy[k] = 1'b0;
        acc_n[k]  = 1'b0;
        ret_n[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        nlat = 16 / RPC_T[k];
        if (acc_n[k]) begin
          m_busy[k] = 1'b1;
          m_cyc[k]  = 0;
        end else if (ret_n[k]) begin
          m_busy[k] = 1'b0;
        end else if (m_busy[k]) begin
          m_cyc[k]++;
        end
        exp_done = m_busy[k] && (m_cyc[k] >= nlat);
        chk("in_ready", k, 64'(in_ready_v[k]), 64'(!m_busy[k]));
        chk("busy", k, 64'(busy_v[k]), 64'(m_busy[k]));
        chk("out_valid", k, 64'(out_valid_v[k]), 64'(exp_done));
        if (exp_done) begin
          chk("out_block", k, out_block_v[k], m_exp[k]);
          if (out_ready && m_lit[k]) chk("out_block_literal", k, out_block_v[k], m_litv[k]);
        end
        acc_n[k] = !m_busy[k] && in_valid;
        ret_n[k] = exp_done && out_ready;
        if (acc_n[k]) begin
          m_exp[k]  = des_ref(in_block, in_keys, in_decrypt);
          m_lit[k]  = lit_en;
          m_litv[k] = lit_val;
          if (lit_en && k == 0) chk("model_literal", k, m_exp[k], lit_val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic scramble();
    in_block   = {$urandom(), $urandom()};
    in_decrypt = 1'($urandom_range(0, 1));
    for (int w = 0; w < 24; w++) in_keys[32*w +: 32] = $urandom();
  endtask

  // Present one block for one edge, then disturb the inputs right after accept.
  task automatic send(input logic [63:0] blk, input logic [767:0] ks, input logic dec,
                      input logic le, input logic [63:0] lv);
    in_valid   = 1'b1;
    in_block   = blk;
    in_keys    = ks;
    in_decrypt = dec;
    lit_en     = le;
    lit_val    = lv;
    step();
    in_valid = 1'b0;
    lit_en   = 1'b0;
    scramble();
  endtask

  initial begin
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_decrypt = 1'b0;
    in_block   = '0;
    in_keys    = '0;
    lit_en     = 1'b0;
    lit_val    = '0;
    gold_ks    = ksched(GOLD_KEY);
    rst        = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Golden encrypt and decrypt across all unroll factors.
    out_ready = 1'b1;
    send(GOLD_PT, gold_ks, 1'b0, 1'b1, GOLD_CT);
    repeat (20) step();
    send(GOLD_CT, gold_ks, 1'b1, 1'b1, GOLD_PT);
    repeat (20) step();

    // Back-pressure: results held in DONE while a second block is offered.
    out_ready = 1'b0;
    send(GOLD_PT, gold_ks, 1'b0, 1'b1, GOLD_CT);
    repeat (20) step();
    in_valid = 1'b1;
    scramble();
    repeat (10) step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    repeat (20) step();

    // Reset during RUN cycle 7, then a fresh golden encrypt.
    send(GOLD_PT, gold_ks, 1'b0, 1'b0, 64'd0);
    repeat (5) step();
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
    send(GOLD_PT, gold_ks, 1'b0, 1'b1, GOLD_CT);
    repeat (20) step();

    // Randomised traffic with random output back-pressure.
    for (int t = 0; t < 30; t++) begin
      scramble();
      send(in_block, in_keys, in_decrypt, 1'b0, 64'd0);
      for (int c = 0; c < 22; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
      out_ready = 1'b1;
      repeat (3) step();
    end

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
